// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single register-file write port. Out of reset it zero-fills every
//   register, one per cycle, then arbitrates the port between requester A
//   (load writeback, normally preferred) and requester B (ALU writeback). B is
//   forced the grant after STARVE_LIMIT consecutive denials. All write-port
//   outputs are registered, so an acceptance shows up on the port one cycle later.
//
// Ports
//   i_clk, i_rst_n                  clock (rising edge), asynchronous active-low reset
//   i_a_valid/o_a_ready/i_a_num/i_a_data   requester A handshake and payload
//   i_b_valid/o_b_ready/i_b_num/i_b_data   requester B handshake and payload
//   o_rf_wr_enable/o_rf_wr_num/o_rf_wr_data  registered register-file write port
//   o_init_done                     clear finished, arbitration active (registered)

module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter int unsigned REG_FILE_SIZE = 32,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_a_valid,
    output logic                     o_a_ready,
    input  logic [REG_NUM_WIDTH-1:0] i_a_num,
    input  logic [DATA_WIDTH-1:0]    i_a_data,
    input  logic                     i_b_valid,
    output logic                     o_b_ready,
    input  logic [REG_NUM_WIDTH-1:0] i_b_num,
    input  logic [DATA_WIDTH-1:0]    i_b_data,
    output logic                     o_rf_wr_enable,
    output logic [REG_NUM_WIDTH-1:0] o_rf_wr_num,
    output logic [DATA_WIDTH-1:0]    o_rf_wr_data,
    output logic                     o_init_done
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    // Counter must hold the value STARVE_LIMIT itself (saturating).
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]         STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [REG_NUM_WIDTH-1:0] CLR_LAST   = REG_NUM_WIDTH'(REG_FILE_SIZE - 1);

    logic                     r_state;
    logic [REG_NUM_WIDTH-1:0] r_clr_idx;
    logic [CNT_W-1:0]         r_starve_cnt;
    logic                     r_wr_enable;
    logic [REG_NUM_WIDTH-1:0] r_wr_num;
    logic [DATA_WIDTH-1:0]    r_wr_data;
    logic                     r_init_done;

    logic w_run;
    logic w_force_b;
    logic w_a_ready;
    logic w_b_ready;
    logic w_a_acc;
    logic w_b_acc;

    // With STARVE_LIMIT=0 the counter never leaves 0, so force_b == b_valid.
    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_force_b = i_b_valid && (r_starve_cnt == STARVE_MAX);
        w_a_ready = w_run && !w_force_b;
        w_b_ready = w_run && (!i_a_valid || w_force_b);
        // Mutually exclusive: A wins only without force_b, B beats a valid A only with it.
        w_a_acc   = i_a_valid && w_a_ready;
        w_b_acc   = i_b_valid && w_b_ready;
    end

    assign o_a_ready      = w_a_ready;
    assign o_b_ready      = w_b_ready;
    assign o_rf_wr_enable = r_wr_enable;
    assign o_rf_wr_num    = r_wr_num;
    assign o_rf_wr_data   = r_wr_data;
    assign o_init_done    = r_init_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_idx   <= '0;
            r_wr_enable <= 1'b0;
            r_wr_num    <= '0;
            r_wr_data   <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_wr_enable <= 1'b1;
            r_wr_num    <= r_clr_idx;
            r_wr_data   <= '0;
            r_clr_idx   <= r_clr_idx + REG_NUM_WIDTH'(1);
            if (r_clr_idx == CLR_LAST) begin
                r_state     <= ST_RUN;
                r_init_done <= 1'b1;
            end
        end else begin
            // Register 0 writes complete the handshake but are suppressed here.
            if (w_a_acc) begin
                r_wr_enable <= (i_a_num != '0);
                r_wr_num    <= i_a_num;
                r_wr_data   <= i_a_data;
            end else if (w_b_acc) begin
                r_wr_enable <= (i_b_num != '0);
                r_wr_num    <= i_b_num;
                r_wr_data   <= i_b_data;
            end else begin
                r_wr_enable <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_run && i_b_valid && !w_b_ready) begin
            if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Two instances share all inputs:
// u_dut4 (STARVE_LIMIT=4) and u_dut0 (STARVE_LIMIT=0); `sel` chooses which
// one's outputs are compared. Expected port writes go into a queue as stimulus
// is driven and are popped after the following clock edge.

module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_num;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_num;
    logic [31:0] b_data;

    logic        a_ready4, b_ready4, en4, done4;
    logic [4:0]  num4;
    logic [31:0] data4;
    logic        a_ready0, b_ready0, en0, done0;
    logic [4:0]  num0;
    logic [31:0] data0;

    regfile_write_arbiter #(.STARVE_LIMIT(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .o_a_ready(a_ready4), .i_a_num(a_num), .i_a_data(a_data),
        .i_b_valid(b_valid), .o_b_ready(b_ready4), .i_b_num(b_num), .i_b_data(b_data),
        .o_rf_wr_enable(en4), .o_rf_wr_num(num4), .o_rf_wr_data(data4), .o_init_done(done4)
    );

    regfile_write_arbiter #(.STARVE_LIMIT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .o_a_ready(a_ready0), .i_a_num(a_num), .i_a_data(a_data),
        .i_b_valid(b_valid), .o_b_ready(b_ready0), .i_b_num(b_num), .i_b_data(b_data),
        .o_rf_wr_enable(en0), .o_rf_wr_num(num0), .o_rf_wr_data(data0), .o_init_done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        o_ar, o_br, o_en, o_done;
    logic [4:0]  o_num;
    logic [31:0] o_data;
    assign o_ar   = sel ? a_ready0 : a_ready4;
    assign o_br   = sel ? b_ready0 : b_ready4;
    assign o_en   = sel ? en0 : en4;
    assign o_done = sel ? done0 : done4;
    assign o_num  = sel ? num0 : num4;
    assign o_data = sel ? data0 : data4;

    typedef struct packed {
        logic        en;
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  last_num;
    logic [31:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop one expected write and compare it against the port (called #1 after posedge).
    task automatic check_write(input string tag);
        wr_t e;
        e = exp_q.pop_front();
        chk({tag, ".en"}, {31'd0, o_en}, {31'd0, e.en});
        chk({tag, ".num"}, {27'd0, o_num}, {27'd0, e.num});
        chk({tag, ".data"}, o_data, e.data);
    endtask

    // Expects to be entered at a negedge right after reset release.
    task automatic clear_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{en: 1'b1, num: 5'(i), data: 32'd0});
            if (i < 31) begin
                chk({tag, ".ready_a"}, {31'd0, o_ar}, 32'd0);
                chk({tag, ".ready_b"}, {31'd0, o_br}, 32'd0);
            end
            @(posedge clk);
            #1;
            check_write(tag);
            chk({tag, ".init_done"}, {31'd0, o_done}, {31'd0, (i == 31)});
            @(negedge clk);
        end
        last_num  = 5'd31;
        last_data = 32'd0;
    endtask

    // One RUN cycle: drive at negedge, check readies, predict the registered write.
    task automatic cycle(input string tag,
                         input logic av, input logic [4:0] an, input logic [31:0] ad,
                         input logic bv, input logic [4:0] bn, input logic [31:0] bd,
                         input logic ear, input logic ebr);
        a_valid = av; a_num = an; a_data = ad;
        b_valid = bv; b_num = bn; b_data = bd;
        #1;
        chk({tag, ".a_ready"}, {31'd0, o_ar}, {31'd0, ear});
        chk({tag, ".b_ready"}, {31'd0, o_br}, {31'd0, ebr});
        if (av && ear) begin
            exp_q.push_back('{en: (an != 5'd0), num: an, data: ad});
            last_num = an; last_data = ad;
        end else if (bv && ebr) begin
            exp_q.push_back('{en: (bn != 5'd0), num: bn, data: bd});
            last_num = bn; last_data = bd;
        end else begin
            exp_q.push_back('{en: 1'b0, num: last_num, data: last_data});
        end
        @(posedge clk);
        #1;
        check_write(tag);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".en"}, {31'd0, o_en}, 32'd0);
        chk({tag, ".num"}, {27'd0, o_num}, 32'd0);
        chk({tag, ".data"}, o_data, 32'd0);
        chk({tag, ".init_done"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        int ka;
        sel = 1'b0;
        rst_n = 1'b0;
        a_valid = 1'b0; a_num = '0; a_data = '0;
        b_valid = 1'b0; b_num = '0; b_data = '0;
        last_num = '0; last_data = '0;
        #3;
        check_reset_outputs("reset");

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_seq("clear", 32);

        // A alone
        cycle("a_only", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("idle1", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);

        // Both valid: A,A,A,A,B repeating; A's payload only advances when granted.
        ka = 0;
        for (int i = 0; i < 10; i++) begin
            logic gb;
            gb = ((i % 5) == 4);
            cycle($sformatf("both%0d", i), 1'b1, 5'(ka + 1), 32'hA000_0000 + 32'(ka),
                  1'b1, 5'd20, 32'hB0B0_0000 + 32'(i), !gb, gb);
            if (!gb) ka++;
        end
        // Counter cleared by last B grant: A wins again.
        cycle("after_b", 1'b1, 5'(ka + 1), 32'hA000_00FF, 1'b1, 5'd21, 32'hB1, 1'b1, 1'b0);
        cycle("idle2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);

        // B to r0: handshake completes, no write
        cycle("b_r0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1);
        cycle("b_r3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h5678, 1'b1, 1'b1);
        cycle("idle3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);

        // Mid-run reset: outputs clear without a clock edge
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        clear_seq("clr_part", 11);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_clr10");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_seq("clr_again", 32);

        // STARVE_LIMIT=0 instance: B always wins when valid
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("lim0_both%0d", i), 1'b1, 5'd9, 32'hAAAA_0009,
                  1'b1, 5'(10 + i), 32'hBBBB_0000 + 32'(i), 1'b0, 1'b1);
        end
        cycle("lim0_a_only", 1'b1, 5'd9, 32'hAAAA_0009, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("lim0_both_again", 1'b1, 5'd12, 32'hAAAA_000C, 1'b1, 5'd13, 32'hBBBB_000D,
              1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
